eu_xbuf_mc: RTL and testbench
=============================

Name: eu_xbuf_mc

Overview:
- Parametrised, multi-channel, read-once foreign-operand buffer. Successor to the single-channel exec-unit X buffer.
- Sits in the exec-unit cache between the interconnect and the operand-prepare stage.
- Stores NUM_WR_CH incoming operand writes per cycle and serves NUM_RD_CH operand lookups per cycle.
- A hit consumes (invalidates) the entry. Reports occupancy so the interconnect can throttle.

Parameters:
- NUM_WR_CH, 2, number of interconnect write channels
- NUM_RD_CH, 2, number of lookup ports (op0, op1, ...)
- NUM_ENTRIES, 8, fully associative entries; power of two, >=2
- ADDR_W, 8, operand address width (euidx/uid/spec packed)
- DATA_W, 16, operand data width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- wr_valid_i  in  NUM_WR_CH  per-channel write request
- wr_addr_i  in  NUM_WR_CH*ADDR_W  packed write addresses, ch0 in LSBs
- wr_data_i  in  NUM_WR_CH*DATA_W  packed write data
- wr_success_o  out  NUM_WR_CH  write accepted this cycle (combinational)
- rd_valid_i  in  NUM_RD_CH  lookup request
- rd_addr_i  in  NUM_RD_CH*ADDR_W  packed lookup addresses
- rd_data_o  out  NUM_RD_CH*DATA_W  hit data (0 on miss)
- rd_success_o  out  NUM_RD_CH  hit this cycle (combinational)
- occupancy_o  out  $clog2(NUM_ENTRIES)+1  registered count of valid entries
- full_o  out  1  occupancy_o == NUM_ENTRIES

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on reset_n.
- Storage: entry = {valid, addr, data}.
- Reset: on any clk edge with reset_n=0, all valid bits clear and occupancy_o=0. While reset_n=0, wr_success_o, rd_success_o and rd_data_o are forced to 0. Reset mid-operation discards all stored operands; no write issued in that cycle is stored.
- Lookup: combinational, zero latency. rd_success_o[r] = rd_valid_i[r] and a valid entry has a matching address. rd_data_o[r] = that entry's data.
- Consume: at the next edge, the hit entry's valid bit clears. If several read ports hit the same entry, all ports get the data and the entry is freed once.
- Write, address already present (valid entry with matching addr): data is overwritten in place, success=1, occupancy unchanged.
- Write, new address: the channel takes the lowest-index free entry not claimed by a lower channel, success=1, stored at the next edge.
- Write, no free entry: success=0 and nothing is stored. The sender must hold and retry.
- Free-entry calculation uses current-cycle valid bits only. Entries freed by reads in the same cycle are reusable next cycle.
- Same-cycle duplicate: if two write channels carry the same address, the lower channel wins (success=1) and the higher gets success=0.
- Write/read same cycle, same address: with the feature off, the read misses. The data is visible from the next cycle.
- Write/read same cycle, different entries: independent.
- Read hit plus overwrite of the same stored address in one cycle: the read returns the old data, the entry stays valid with the new data, and the write counts as new.
- Occupancy: occupancy_o(next) = occupancy_o + new_writes − freed_entries. Never below 0 or above NUM_ENTRIES.
- Handshake: wr_success_o and rd_success_o are valid in the same cycle as the request. There is no backpressure on the read side.

Optional Feature:
- Macro: EU_XBUF_MC_BYPASS_EN.
- When defined:
  - A read whose address misses storage but matches a same-cycle wr_valid_i channel returns that channel's wr_data_i with rd_success_o=1. The lowest matching channel wins.
  - That write is consumed: wr_success_o=1 and nothing is stored, so no entry is used and occupancy is unchanged.
  - Bypass is allowed even when full_o=1.
- When undefined: no bypass; behaviour exactly as above.

Test Plan:
- Reset then write ch0 addr=0x12 data=0xBEEF -> wr_success_o[0]=1; next cycle rd port0 addr=0x12 -> rd_success_o[0]=1, rd_data_o=0xBEEF, occupancy 1->0 on the following edge.
- Fill 8 distinct addresses, then write a ninth -> full_o=1, wr_success_o=0; read one address and retry the ninth in the same cycle -> still 0; retry next cycle -> 1.
- Both write channels addr=0x20 (data 0x1111 / 0x2222) -> success=2'b01; a read returns 0x1111.
- Both read ports addr=0x30 with it stored -> both hit with the same data; occupancy decrements by 1.
- Write and read addr=0x40 same cycle -> without macro: miss, then hit next cycle; with EU_XBUF_MC_BYPASS_EN: immediate hit and occupancy unchanged.
- Load 4 entries, assert reset_n=0 for one edge while writing -> occupancy_o=0, all success outputs 0 during reset, all later reads miss.

Source files
------------

// File: rtl/eu_xbuf_mc.sv
// Multi-channel read-once operand buffer: fully associative, consumed on lookup hit.
// Define EU_XBUF_MC_BYPASS_EN to let a lookup be served directly by a same-cycle write.
module eu_xbuf_mc #(
    parameter int unsigned NUM_WR_CH   = 2,
    parameter int unsigned NUM_RD_CH   = 2,
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    localparam int unsigned OCC_W      = $clog2(NUM_ENTRIES) + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_WR_CH-1:0]          wr_valid_i,
    input  logic [NUM_WR_CH*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR_CH*DATA_W-1:0]   wr_data_i,
    output logic [NUM_WR_CH-1:0]          wr_success_o,
    input  logic [NUM_RD_CH-1:0]          rd_valid_i,
    input  logic [NUM_RD_CH*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD_CH*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD_CH-1:0]          rd_success_o,
    output logic [OCC_W-1:0]              occupancy_o,
    output logic                          full_o
);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]      addr_q [NUM_ENTRIES];
    logic [ADDR_W-1:0]      addr_d [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_d [NUM_ENTRIES];
    logic [OCC_W-1:0]       occ_q, occ_d;

    logic [NUM_RD_CH-1:0]   rd_hit;
    logic [NUM_RD_CH-1:0]   rd_success;
    logic [DATA_W-1:0]      rd_data [NUM_RD_CH];
    logic [NUM_ENTRIES-1:0] consume;

    logic [NUM_WR_CH-1:0]   wr_success;
    logic [NUM_ENTRIES-1:0] wr_en;
    logic [NUM_ENTRIES-1:0] claimed;
    logic [ADDR_W-1:0]      wr_addr_e [NUM_ENTRIES];
    logic [DATA_W-1:0]      wr_data_e [NUM_ENTRIES];
    logic [ADDR_W-1:0]      wa;
    logic [DATA_W-1:0]      wd;
    logic                   dup, present, found, byp;

    // Lookup against stored entries; addresses in storage are unique, so at most one match.
    always_comb begin
        rd_hit     = '0;
        rd_success = '0;
        consume    = '0;
        for (int r = 0; r < NUM_RD_CH; r++) begin
            rd_data[r] = '0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (valid_q[e] && addr_q[e] == rd_addr_i[r*ADDR_W +: ADDR_W]) begin
                    rd_hit[r]  = 1'b1;
                    rd_data[r] = data_q[e];
                    if (rd_valid_i[r] && reset_n) consume[e] = 1'b1;
                end
            end
            rd_success[r] = rd_valid_i[r] && rd_hit[r] && reset_n;
`ifdef EU_XBUF_MC_BYPASS_EN
            if (rd_valid_i[r] && !rd_hit[r] && reset_n) begin
                for (int w = NUM_WR_CH - 1; w >= 0; w--) begin
                    if (wr_valid_i[w] && wr_addr_i[w*ADDR_W +: ADDR_W] ==
                        rd_addr_i[r*ADDR_W +: ADDR_W]) begin
                        rd_success[r] = 1'b1;
                        rd_data[r]    = wr_data_i[w*DATA_W +: DATA_W];
                    end
                end
            end
`endif
            if (!rd_success[r]) rd_data[r] = '0;
        end
    end

    // Write allocation: in-place overwrite, else lowest free entry not taken by a lower channel.
    always_comb begin
        wr_success = '0;
        wr_en      = '0;
        claimed    = '0;
        wa         = '0;
        wd         = '0;
        dup        = 1'b0;
        present    = 1'b0;
        found      = 1'b0;
        byp        = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            wr_addr_e[e] = '0;
            wr_data_e[e] = '0;
        end
        for (int w = 0; w < NUM_WR_CH; w++) begin
            wa      = wr_addr_i[w*ADDR_W +: ADDR_W];
            wd      = wr_data_i[w*DATA_W +: DATA_W];
            dup     = 1'b0;
            present = 1'b0;
            found   = 1'b0;
            byp     = 1'b0;
            for (int v = 0; v < NUM_WR_CH; v++) begin
                if (v < w && wr_valid_i[v] && wr_addr_i[v*ADDR_W +: ADDR_W] == wa) dup = 1'b1;
            end
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (valid_q[e] && addr_q[e] == wa) present = 1'b1;
            end
`ifdef EU_XBUF_MC_BYPASS_EN
            for (int r = 0; r < NUM_RD_CH; r++) begin
                if (rd_valid_i[r] && !present && rd_addr_i[r*ADDR_W +: ADDR_W] == wa) byp = 1'b1;
            end
`endif
            if (reset_n && wr_valid_i[w] && !dup) begin
                if (byp) begin
                    wr_success[w] = 1'b1;
                end else begin
                    for (int e = 0; e < NUM_ENTRIES; e++) begin
                        if (present ? (valid_q[e] && addr_q[e] == wa)
                                    : (!found && !valid_q[e] && !claimed[e])) begin
                            found         = 1'b1;
                            claimed[e]    = 1'b1;
                            wr_en[e]      = 1'b1;
                            wr_addr_e[e]  = wa;
                            wr_data_e[e]  = wd;
                            wr_success[w] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A consumed entry that is overwritten in the same cycle stays valid with the new data.
    always_comb begin
        occ_d = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            valid_d[e] = (valid_q[e] && !consume[e]) || wr_en[e];
            addr_d[e]  = wr_en[e] ? wr_addr_e[e] : addr_q[e];
            data_d[e]  = wr_en[e] ? wr_data_e[e] : data_q[e];
            occ_d      = occ_d + OCC_W'(valid_d[e]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            addr_q[e] <= addr_d[e];
            data_q[e] <= data_d[e];
        end
    end

    for (genvar r = 0; r < NUM_RD_CH; r++) begin : g_rd_out
        assign rd_data_o[r*DATA_W +: DATA_W] = rd_data[r];
    end

    assign rd_success_o = rd_success;
    assign wr_success_o = wr_success;
    assign occupancy_o  = occ_q;
    assign full_o       = (occ_q == OCC_W'(NUM_ENTRIES));

endmodule

// File: tb/tb_eu_xbuf_mc.sv
// Scoreboard bench for eu_xbuf_mc: the driver queues per-cycle expectations, a monitor
// pops and compares them mid-cycle.
module tb_eu_xbuf_mc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  wr_valid_i = '0;
    logic [15:0] wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic [1:0]  wr_success_o;
    logic [1:0]  rd_valid_i = '0;
    logic [15:0] rd_addr_i = '0;
    logic [31:0] rd_data_o;
    logic [1:0]  rd_success_o;
    logic [3:0]  occupancy_o;
    logic        full_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [1:0]  ws;
        logic [1:0]  rs;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [3:0]  occ;
        logic        full;
    } exp_t;

    exp_t exp_q[$];

    eu_xbuf_mc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid_i   (wr_valid_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_success_o (wr_success_o),
        .rd_valid_i   (rd_valid_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_success_o (rd_success_o),
        .occupancy_o  (occupancy_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
        end
    endtask

    // Monitor: outputs are combinational/registered, so each cycle presents a response.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "wr_success", 32'(wr_success_o), 32'(e.ws));
            chk(e.name, "rd_success", 32'(rd_success_o), 32'(e.rs));
            chk(e.name, "rd_data0", 32'(rd_data_o[15:0]), 32'(e.d0));
            chk(e.name, "rd_data1", 32'(rd_data_o[31:16]), 32'(e.d1));
            chk(e.name, "occupancy", 32'(occupancy_o), 32'(e.occ));
            chk(e.name, "full", 32'(full_o), 32'(e.full));
        end
    end

    task automatic step(input string n, input logic rst_n,
                        input logic [1:0] wv, input logic [7:0] wa0, input logic [15:0] wd0,
                        input logic [7:0] wa1, input logic [15:0] wd1,
                        input logic [1:0] rv, input logic [7:0] ra0, input logic [7:0] ra1,
                        input logic [1:0] ews, input logic [1:0] ers,
                        input logic [15:0] ed0, input logic [15:0] ed1,
                        input logic [3:0] eocc, input logic efull);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n    = rst_n;
        wr_valid_i = wv;
        wr_addr_i  = {wa1, wa0};
        wr_data_i  = {wd1, wd0};
        rd_valid_i = rv;
        rd_addr_i  = {ra1, ra0};
        e.name = n; e.ws = ews; e.rs = ers; e.d0 = ed0; e.d1 = ed1;
        e.occ = eocc; e.full = efull;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string n, input logic [3:0] eocc, input logic efull);
        step(n, 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b00, 2'b00, 16'h0, 16'h0, eocc, efull);
    endtask

    initial begin
        step("reset", 1'b0, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b00, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("wr12", 1'b1, 2'b01, 8'h12, 16'hBEEF, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("rd12", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b01, 8'h12, 8'h0,
             2'b00, 2'b01, 16'hBEEF, 16'h0, 4'd1, 1'b0);
        idle("after_rd12", 4'd0, 1'b0);
        // Fill all eight entries.
        for (int i = 0; i < 4; i++) begin
            step("fill", 1'b1, 2'b11, 8'(8'h50 + 2*i), 16'(16'h1000 + 2*i),
                 8'(8'h51 + 2*i), 16'(16'h1001 + 2*i), 2'b00, 8'h0, 8'h0,
                 2'b11, 2'b00, 16'h0, 16'h0, 4'(2*i), 1'b0);
        end
        step("wr_full", 1'b1, 2'b01, 8'h58, 16'h1008, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b00, 2'b00, 16'h0, 16'h0, 4'd8, 1'b1);
        step("rd_retry_same", 1'b1, 2'b01, 8'h58, 16'h1008, 8'h0, 16'h0, 2'b01, 8'h50, 8'h0,
             2'b00, 2'b01, 16'h1000, 16'h0, 4'd8, 1'b1);
        step("retry_next", 1'b1, 2'b01, 8'h58, 16'h1008, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd7, 1'b0);
        // Drain two per cycle.
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b11,
                 8'(8'h51 + 2*i), 8'(8'h52 + 2*i),
                 2'b00, 2'b11, 16'(16'h1001 + 2*i), 16'(16'h1002 + 2*i),
                 4'(8 - 2*i), (i == 0));
        end
        idle("drained", 4'd0, 1'b0);
        step("dup_wr", 1'b1, 2'b11, 8'h20, 16'h1111, 8'h20, 16'h2222, 2'b00, 8'h0, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("dup_rd", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b01, 8'h20, 8'h0,
             2'b00, 2'b01, 16'h1111, 16'h0, 4'd1, 1'b0);
        step("wr30", 1'b1, 2'b01, 8'h30, 16'h3333, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("dual_rd30", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b11, 8'h30, 8'h30,
             2'b00, 2'b11, 16'h3333, 16'h3333, 4'd1, 1'b0);
        idle("after_dual", 4'd0, 1'b0);
`ifdef EU_XBUF_MC_BYPASS_EN
        step("wrrd40", 1'b1, 2'b01, 8'h40, 16'h4444, 8'h0, 16'h0, 2'b01, 8'h40, 8'h0,
             2'b01, 2'b01, 16'h4444, 16'h0, 4'd0, 1'b0);
        step("rd40", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b01, 8'h40, 8'h0,
             2'b00, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        idle("after40", 4'd0, 1'b0);
`else
        step("wrrd40", 1'b1, 2'b01, 8'h40, 16'h4444, 8'h0, 16'h0, 2'b01, 8'h40, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("rd40", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b01, 8'h40, 8'h0,
             2'b00, 2'b01, 16'h4444, 16'h0, 4'd1, 1'b0);
        idle("after40", 4'd0, 1'b0);
`endif
        // Read hit and overwrite of the same address in one cycle.
        step("wr60", 1'b1, 2'b01, 8'h60, 16'h6001, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("rdwr60", 1'b1, 2'b01, 8'h60, 16'h6002, 8'h0, 16'h0, 2'b01, 8'h60, 8'h0,
             2'b01, 2'b01, 16'h6001, 16'h0, 4'd1, 1'b0);
        step("rd60", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b01, 8'h60, 8'h0,
             2'b00, 2'b01, 16'h6002, 16'h0, 4'd1, 1'b0);
        idle("after60", 4'd0, 1'b0);
        // In-place overwrite on channel 1, read on port 1.
        step("wr61", 1'b1, 2'b01, 8'h61, 16'h0A0A, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("ovw61", 1'b1, 2'b10, 8'h0, 16'h0, 8'h61, 16'h0B0B, 2'b00, 8'h0, 8'h0,
             2'b10, 2'b00, 16'h0, 16'h0, 4'd1, 1'b0);
        step("rd61", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b10, 8'h0, 8'h61,
             2'b00, 2'b10, 16'h0, 16'h0B0B, 4'd1, 1'b0);
        idle("after61", 4'd0, 1'b0);
        // Mid-operation reset discards everything.
        step("ld70", 1'b1, 2'b11, 8'h70, 16'h7070, 8'h71, 16'h7171, 2'b00, 8'h0, 8'h0,
             2'b11, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("ld72", 1'b1, 2'b11, 8'h72, 16'h7272, 8'h73, 16'h7373, 2'b00, 8'h0, 8'h0,
             2'b11, 2'b00, 16'h0, 16'h0, 4'd2, 1'b0);
        step("rst_mid", 1'b0, 2'b11, 8'h74, 16'h7474, 8'h75, 16'h7575, 2'b01, 8'h70, 8'h0,
             2'b00, 2'b00, 16'h0, 16'h0, 4'd4, 1'b0);
        step("post_rst_a", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b11, 8'h70, 8'h71,
             2'b00, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("post_rst_b", 1'b1, 2'b00, 8'h0, 16'h0, 8'h0, 16'h0, 2'b11, 8'h74, 8'h72,
             2'b00, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        step("wr_after_rst", 1'b1, 2'b01, 8'h74, 16'h0074, 8'h0, 16'h0, 2'b00, 8'h0, 8'h0,
             2'b01, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
        idle("final", 4'd1, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
